snake_body_tracer: RTL

SNAKE_BODY_TRACER -- requirements
Module: snake_body_tracer

---
 rtl/snake_pkg.sv | 27 ++
 rtl/snake_coord_step.sv | 34 +++
 rtl/snake_body_tracer.sv | 123 ++++++++++++
 3 files changed

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake body tracer: grid/ring sizes,
// derived field widths, direction codes and the tracer FSM states.
package snake_pkg;

  localparam int DEPTH = 234;
  localparam int COLS  = 16;
  localparam int ROWS  = 12;

  localparam int X_W   = $clog2(COLS);
  localparam int Y_W   = $clog2(ROWS);
  localparam int LEN_W = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SYNC = 2'd1,
    WALK      = 2'd2,
    FIN       = 2'd3
  } state_t;

endpackage

// File: rtl/snake_coord_step.sv
// One grid step in a given direction, wrapping at every edge so the result
// always stays inside 0..COLS-1 / 0..ROWS-1 for any grid size.
module snake_coord_step
  import snake_pkg::*;
#(
  parameter int COLS = snake_pkg::COLS,
  parameter int ROWS = snake_pkg::ROWS
) (
  input  logic [$clog2(COLS)-1:0] x,
  input  logic [$clog2(ROWS)-1:0] y,
  input  dir_t                    dir,
  output logic [$clog2(COLS)-1:0] nx,
  output logic [$clog2(ROWS)-1:0] ny
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);

  always_comb begin
    nx = x;
    ny = y;
    case (dir)
      UP:      ny = (y == '0) ? YW'(ROWS - 1) : y - 1'b1;
      RIGHT:   nx = (x == XW'(COLS - 1)) ? '0 : x + 1'b1;
      DOWN:    ny = (y == YW'(ROWS - 1)) ? '0 : y + 1'b1;
      LEFT:    nx = (x == '0) ? XW'(COLS - 1) : x - 1'b1;
      default: begin
        nx = x;
        ny = y;
      end
    endcase
  end

endmodule

// File: rtl/snake_body_tracer.sv
// Walks the snake body from the head using the circulating direction ring,
// emitting one segment per cycle and recording the first hit on a query cell.
module snake_body_tracer
  import snake_pkg::*;
#(
  parameter int DEPTH = snake_pkg::DEPTH,
  parameter int COLS  = snake_pkg::COLS,
  parameter int ROWS  = snake_pkg::ROWS
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic                           sync,
  input  logic [1:0]                     dir_in,
  input  logic [$clog2(COLS)-1:0]        head_x,
  input  logic [$clog2(ROWS)-1:0]        head_y,
  input  logic [$clog2(DEPTH+1)-1:0]     length,
  input  logic [$clog2(COLS)-1:0]        query_x,
  input  logic [$clog2(ROWS)-1:0]        query_y,
  output logic                           busy,
  output logic                           seg_valid,
  output logic [$clog2(COLS)-1:0]        seg_x,
  output logic [$clog2(ROWS)-1:0]        seg_y,
  output logic [$clog2(DEPTH+1)-1:0]     seg_idx,
  output logic                           done,
  output logic                           hit,
  output logic [$clog2(DEPTH+1)-1:0]     hit_idx
);

  localparam int XW = $clog2(COLS);
  localparam int YW = $clog2(ROWS);
  localparam int LW = $clog2(DEPTH + 1);

  state_t        state;
  state_t        state_next;
  logic [LW-1:0] len_lat;
  logic [LW-1:0] cnt;
  logic          consume;
  logic [XW-1:0] step_x;
  logic [YW-1:0] step_y;
  logic [XW-1:0] nx;
  logic [YW-1:0] ny;

  // The walk steps from the head on the sync cycle, then from the last segment.
  snake_coord_step #(.COLS(COLS), .ROWS(ROWS)) u_step (
    .x   (step_x),
    .y   (step_y),
    .dir (dir_t'(dir_in)),
    .nx  (nx),
    .ny  (ny)
  );

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    consume    = 1'b0;
    step_x     = seg_x;
    step_y     = seg_y;
    case (state)
      IDLE: begin
        if (start) state_next = WAIT_SYNC;
      end
      WAIT_SYNC: begin
        step_x = head_x;
        step_y = head_y;
        if (sync) begin
          if (len_lat == '0) begin
            state_next = FIN;
          end else begin
            state_next = WALK;
            consume    = 1'b1;
          end
        end
      end
      WALK: begin
        if (cnt < len_lat) consume    = 1'b1;
        else               state_next = FIN;
      end
      FIN:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // cnt is cleared on start, so cnt+1 is the index of the segment being produced.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy      <= 1'b0;
      done      <= 1'b0;
      seg_valid <= 1'b0;
      seg_x     <= '0;
      seg_y     <= '0;
      seg_idx   <= '0;
      hit       <= 1'b0;
      hit_idx   <= '0;
      len_lat   <= '0;
      cnt       <= '0;
    end else begin
      busy      <= (state_next == WAIT_SYNC) || (state_next == WALK);
      done      <= (state_next == FIN);
      seg_valid <= consume;
      if (consume) begin
        seg_x   <= nx;
        seg_y   <= ny;
        seg_idx <= cnt + 1'b1;
        cnt     <= cnt + 1'b1;
      end
      if ((state == IDLE) && start) begin
        len_lat <= (length > LW'(DEPTH)) ? LW'(DEPTH) : length;
        cnt     <= '0;
        hit     <= 1'b0;
        hit_idx <= '0;
      end else if (seg_valid && !hit && (seg_x == query_x) && (seg_y == query_y)) begin
        hit     <= 1'b1;
        hit_idx <= seg_idx;
      end
    end
  end

endmodule
